// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-stage redirect/address bundle for the instruction-pointer generator.
//   stall                   pipeline stall vector, bit 0 holds pc
//   flush / flush_pc        exception or eret redirect and its target
//   branch_flag_i           decode-stage branch taken
//   branch_target_address_i branch target
//   pc / ce                 fetch address and fetch enable to instruction memory
//   redirect_pending        a branch taken during a stall is being held
//   pc_misalign             current pc has nonzero low log2(INC) bits
// master: pipeline/control side. slave: the pc generator.
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    logic               branch_flag_i;
    logic [ADDR_W-1:0]  branch_target_address_i;
    logic [ADDR_W-1:0]  pc;
    logic               ce;
    logic               redirect_pending;
    logic               pc_misalign;

    modport master (
        output stall, flush, flush_pc, branch_flag_i, branch_target_address_i,
        input  pc, ce, redirect_pending, pc_misalign
    );

    modport slave (
        input  stall, flush, flush_pc, branch_flag_i, branch_target_address_i,
        output pc, ce, redirect_pending, pc_misalign
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage instruction-pointer generator.
// Redirect priority: flush, buffered branch, live branch, sequential (pc + INC).
// A branch seen while stalled is held in a pending register and applied on the first
// unstalled cycle, so it is never lost; a newer stalled branch replaces an older one.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pc_gen_if.slave: stall/flush/branch inputs, pc/ce/redirect_pending/pc_misalign out
// All outputs are registered. pc_misalign flags a loaded pc whose low log2(INC) bits are
// nonzero; pc itself is loaded unmodified so downstream exception logic can trap on it.
module pc_gen #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC = '0,
    parameter int unsigned          INC       = 4,
    parameter int unsigned          STALL_W   = 6
) (
    input  logic    clk,
    input  logic    rst,
    pc_gen_if.slave bus
);

    // INC is a power of two, so INC-1 masks the bits that must be zero; INC=1 gives mask 0.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INC - 1);
    localparam logic [ADDR_W-1:0] INC_VAL    = ADDR_W'(INC);

    typedef enum logic {StBoot, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_target_q;
    logic              pend_vld_q;
    logic              ce_q;
    logic              misalign_q;

    // Only stall[0] matters here; the remaining bits belong to later stages.
    logic unused_stall;
    assign unused_stall = ^bus.stall;

    function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_VEC;
            pend_target_q <= '0;
            pend_vld_q    <= 1'b0;
            ce_q          <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            unique case (state_q)
                // One idle edge after reset: raise ce so RESET_VEC is the first fetch.
                StBoot: begin
                    ce_q    <= 1'b1;
                    state_q <= StRun;
                end
                StRun: begin
                    if (bus.flush) begin
                        pc_q       <= bus.flush_pc;
                        misalign_q <= misaligned(bus.flush_pc);
                        pend_vld_q <= 1'b0;
                    end else if (!bus.stall[0]) begin
                        if (pend_vld_q) begin
                            // Buffered branch wins over a live one in the same cycle.
                            pc_q       <= pend_target_q;
                            misalign_q <= misaligned(pend_target_q);
                            pend_vld_q <= 1'b0;
                        end else if (bus.branch_flag_i) begin
                            pc_q       <= bus.branch_target_address_i;
                            misalign_q <= misaligned(bus.branch_target_address_i);
                        end else begin
                            // Wraps silently modulo 2^ADDR_W.
                            pc_q       <= pc_q + INC_VAL;
                            misalign_q <= misaligned(pc_q + INC_VAL);
                        end
                    end else if (bus.branch_flag_i) begin
                        pend_target_q <= bus.branch_target_address_i;
                        pend_vld_q    <= 1'b1;
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    assign bus.pc               = pc_q;
    assign bus.ce               = ce_q;
    assign bus.redirect_pending = pend_vld_q;
    assign bus.pc_misalign      = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned INC       = 4;
    localparam int unsigned STALL_W   = 6;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
        logic        pend;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_gen_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W)) bus ();

    pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_VEC(RESET_VEC),
        .INC      (INC),
        .STALL_W  (STALL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: architectural view of the fetch pointer.
    logic [31:0] m_pc     = RESET_VEC;
    bit          m_ce     = 1'b0;
    bit          m_booted = 1'b0;
    logic [31:0] m_pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    endtask

    task automatic model_step(input bit r, input logic [STALL_W-1:0] st, input bit fl,
                              input logic [31:0] fpc, input bit br, input logic [31:0] tgt);
        if (r) begin
            m_pc = RESET_VEC; m_ce = 1'b0; m_booted = 1'b0; m_pend.delete();
        end else if (!m_booted) begin
            m_booted = 1'b1; m_ce = 1'b1;
        end else if (fl) begin
            m_pc = fpc; m_pend.delete();
        end else if (!st[0] && m_pend.size() != 0) begin
            m_pc = m_pend.pop_front();
        end else if (!st[0] && br) begin
            m_pc = tgt;
        end else if (!st[0]) begin
            m_pc = 32'((64'(m_pc) + 64'(INC)) % 64'h1_0000_0000);
        end else if (br) begin
            m_pend.delete();
            m_pend.push_back(tgt);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and queue the state expected after the
    // following rising edge.
    task automatic cyc(input bit r, input logic [STALL_W-1:0] st, input bit fl,
                       input logic [31:0] fpc, input bit br, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.stall = st; bus.flush = fl; bus.flush_pc = fpc;
        bus.branch_flag_i = br; bus.branch_target_address_i = tgt;
        model_step(r, st, fl, fpc, br, tgt);
        e.pc   = m_pc;
        e.ce   = m_ce;
        e.pend = (m_pend.size() != 0);
        e.mis  = (m_pc % INC) != 0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic stall_cyc(input bit br, input logic [31:0] tgt);
        cyc(1'b0, 6'h01, 1'b0, 32'h0, br, tgt);
    endtask

    task automatic branch(input logic [31:0] tgt);
        cyc(1'b0, 6'h00, 1'b0, 32'h0, 1'b1, tgt);
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("ce", 32'(bus.ce), 32'(e.ce));
                check("redirect_pending", 32'(bus.redirect_pending), 32'(e.pend));
                check("pc_misalign", 32'(bus.pc_misalign), 32'(e.mis));
            end
        end
    end

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return $urandom & 32'hFFFF_FFFC;
            1:       return $urandom;
            2:       return 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
            default: return $urandom & 32'h0000_03FF;
        endcase
    endfunction

    initial begin
        bus.stall = '0; bus.flush = 1'b0; bus.flush_pc = '0;
        bus.branch_flag_i = 1'b0; bus.branch_target_address_i = '0;

        // Reset and boot, then sequential fetch up to 0x10.
        repeat (3) cyc(1'b1, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(5);
        // Stall holds pc; upper stall bits are ignored.
        repeat (3) stall_cyc(1'b0, 32'h0);
        cyc(1'b0, 6'h3E, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(2);
        // Branch during stall is buffered, applied on release.
        stall_cyc(1'b1, 32'h0000_0100);
        stall_cyc(1'b1, 32'h0000_0100);
        idle(2);
        // Flush overrides stall and discards a pending branch.
        stall_cyc(1'b1, 32'h0000_0200);
        cyc(1'b0, 6'h01, 1'b1, 32'h0000_0180, 1'b1, 32'h0000_0300);
        idle(2);
        // Newer stalled branch overwrites older; buffered beats live branch.
        stall_cyc(1'b1, 32'h0000_0300);
        stall_cyc(1'b1, 32'h0000_0400);
        branch(32'h0000_0500);
        idle(1);
        // Wrap at the top of the address space.
        branch(32'hFFFF_FFFC);
        idle(2);
        // Misaligned target propagates through sequential fetch.
        branch(32'h0000_0102);
        idle(2);
        // Reset mid-operation drops a pending branch.
        stall_cyc(1'b1, 32'h0000_0800);
        cyc(1'b1, 6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit                 r;
            bit                 fl;
            bit                 br;
            logic [STALL_W-1:0] st;
            r  = ($urandom_range(0, 99) < 2);
            fl = ($urandom_range(0, 99) < 6);
            br = ($urandom_range(0, 99) < 25);
            st = STALL_W'($urandom);
            st[0] = ($urandom_range(0, 99) < 35);
            cyc(r, st, fl, rand_target(), br, rand_target());
        end

        // Drain: every queued expectation must be consumed within a few cycles.
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
